// File: rtl/matrix_pkg.sv
// Shared definitions for the VT1 matrix-processing datapath.
// Holds the matrix geometry, the controller state encoding and the fixed
// 4x4 coefficient matrix A (row-major, A[r][c] = 4*r + c + 1).
package matrix_pkg;

  localparam int unsigned DATA_W = 7;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned N_ELEM = ROWS * COLS;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    OUTPUT,
    DONE
  } state_e;

  typedef logic [DATA_W-1:0] coef_t;

  // Index is {row, col}, i.e. entry 4*r + c.
  localparam coef_t COEF_ROM [ROWS*ROWS] = '{
    7'd1,  7'd2,  7'd3,  7'd4,
    7'd5,  7'd6,  7'd7,  7'd8,
    7'd9,  7'd10, 7'd11, 7'd12,
    7'd13, 7'd14, 7'd15, 7'd16
  };

endpackage

// File: rtl/matrix_mult_core_coef_rom.sv
// Combinational lookup of coefficient A[r][c].
// Ports:
//   addr_i  {r[1:0], c[1:0]} address
//   coef_o  unsigned DATA_W coefficient
module coef_rom
  import matrix_pkg::*;
(
  input  logic [3:0]        addr_i,
  output logic [DATA_W-1:0] coef_o
);

  always_comb begin
    coef_o = COEF_ROM[addr_i];
  end

endmodule

// File: rtl/matrix_mult_core.sv
// VT1 matrix multiply core: loads a 4x8 matrix X serially (row-major),
// computes P = A*X with a single multiply-accumulate per cycle, streams the
// 32 entries of P out in row-major order and then pulses finish.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start_in     level request to process a matrix, sampled in IDLE
//   valid_input  X_load carries an element (LOAD only)
//   X_load       unsigned input element
//   finish       one-cycle pulse after the last result is streamed
//   dout         result element P[i][j]
//   dout_valid   dout valid this cycle
module matrix_mult_core
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              valid_input,
  input  logic [DATA_W-1:0] X_load,
  output logic              finish,
  output logic [ACC_W-1:0]  dout,
  output logic              dout_valid
);

  localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

  state_e              state_q, state_d;
  // Single element index reused as load index, result index and output index.
  logic [4:0]          idx_q, idx_d;
  logic [1:0]          m_q, m_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    dout_q;
  logic                dout_valid_q;
  logic                finish_q;

  logic [DATA_W-1:0]   x_mem   [N_ELEM];
  logic [ACC_W-1:0]    res_mem [N_ELEM];
  logic                x_we, res_we;

  logic [DATA_W-1:0]   coef;
  logic [DATA_W-1:0]   x_elem;
  logic [2*DATA_W-1:0] product;
  logic [ACC_W-1:0]    mac_sum;

  // i = idx_q[4:3], j = idx_q[2:0]; A address {i, m}, X address {m, j}.
  coef_rom u_coef_rom (
    .addr_i ({idx_q[4:3], m_q}),
    .coef_o (coef)
  );

  always_comb begin
    x_elem  = x_mem[{m_q, idx_q[2:0]}];
    product = coef * x_elem;
    // First term of each dot product restarts the accumulator.
    mac_sum = ((m_q == 2'd0) ? '0 : acc_q) + ACC_W'(product);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    m_d     = m_q;
    acc_d   = acc_q;
    x_we    = 1'b0;
    res_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        m_d   = '0;
        if (start_in) state_d = LOAD;
      end
      LOAD: begin
        if (valid_input) begin
          x_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = COMPUTE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      COMPUTE: begin
        acc_d = mac_sum;
        m_d   = m_q + 2'd1;
        if (m_q == 2'd3) begin
          res_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = OUTPUT;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      OUTPUT: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      m_q          <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      m_q          <= m_d;
      acc_q        <= acc_d;
      dout_valid_q <= (state_q == OUTPUT);
      finish_q     <= (state_q == DONE);
      if (state_q == OUTPUT) dout_q <= res_mem[idx_q];
    end
  end

  // Storage arrays carry no reset; their contents are rewritten every pass.
  always_ff @(posedge clk) begin
    if (x_we)   x_mem[idx_q]   <= X_load;
    if (res_we) res_mem[idx_q] <= mac_sum;
  end

  assign finish     = finish_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_matrix_mult_core.sv
module tb_matrix_mult_core;
  import matrix_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_in;
  logic              valid_input;
  logic [DATA_W-1:0] X_load;
  logic              finish;
  logic [ACC_W-1:0]  dout;
  logic              dout_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] got_q[$];
  logic             fin_prev = 1'b0;

  matrix_mult_core dut (
    .clk         (clk),
    .rst         (rst),
    .start_in    (start_in),
    .valid_input (valid_input),
    .X_load      (X_load),
    .finish      (finish),
    .dout        (dout),
    .dout_valid  (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every valid output is matched against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      if (finish && fin_prev) check("finish_width", 2, 1);
      fin_prev = finish;
      if (dout_valid) begin
        got_q.push_back(dout);
        if (exp_q.size() == 0) check("unexpected_dout", int'(dout), -1);
        else check("dout_stream", int'(dout), int'(exp_q.pop_front()));
      end
    end else begin
      fin_prev = 1'b0;
    end
  end

  // mode 0: every element = val; mode 1: X[k] = k.
  task automatic load_matrix(input int mode, input int val, input bit gapped);
    int xs[N_ELEM];
    for (int k = 0; k < N_ELEM; k++) xs[k] = (mode == 0) ? val : k;
    for (int k = 0; k < N_ELEM; k++) begin
      #1 valid_input = 1'b1; X_load = DATA_W'(xs[k]);
      @(posedge clk);
      if (gapped) begin
        #1 valid_input = 1'b0; X_load = 7'h55;
        @(posedge clk);
      end
    end
    #1 valid_input = 1'b0; X_load = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        int s = 0;
        for (int m = 0; m < ROWS; m++) s += (4*i + m + 1) * xs[m*COLS + j];
        exp_q.push_back(ACC_W'(s));
      end
  endtask

  // Returns at the negedge where finish is seen high, or reports a timeout.
  task automatic wait_finish(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (finish) seen = 1'b1;
    end
    if (!seen) check({name, "_finish_timeout"}, 0, 1);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    val;
    bit    gapped;
    int    p00;
    int    p10;
    int    p37;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{"ones",   0, 1,   1'b0, 10,   26,   58};
    vecs[1] = '{"max",    0, 127, 1'b0, 1270, 3302, 7366};
    vecs[2] = '{"gapped", 1, 0,   1'b1, 160,  352,  1142};

    rst = 1'b0; start_in = 1'b0; valid_input = 1'b0; X_load = '0;
    repeat (3) @(negedge clk);
    check("reset_finish", int'(finish), 0);
    check("reset_dout_valid", int'(dout_valid), 0);
    check("reset_dout", int'(dout), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_output", got_q.size(), 0);
    check("idle_finish", int'(finish), 0);

    for (int v = 0; v < 3; v++) begin
      int extra = 0;
      got_q.delete();
      @(negedge clk); start_in = 1'b1;
      @(posedge clk);
      load_matrix(vecs[v].mode, vecs[v].val, vecs[v].gapped);
      start_in = 1'b0;
      wait_finish(vecs[v].name);
      repeat (3) begin @(negedge clk); if (finish) extra++; end
      check({vecs[v].name, "_count"}, got_q.size(), N_ELEM);
      if (got_q.size() == N_ELEM) begin
        check({vecs[v].name, "_p00"}, int'(got_q[0]), vecs[v].p00);
        check({vecs[v].name, "_p10"}, int'(got_q[8]), vecs[v].p10);
        check({vecs[v].name, "_p37"}, int'(got_q[31]), vecs[v].p37);
      end
      check({vecs[v].name, "_single_finish"}, extra, 0);
    end

    // Back-to-back: start_in held through two matrices.
    got_q.delete();
    @(negedge clk); start_in = 1'b1;
    @(posedge clk);
    load_matrix(0, 1, 1'b0);
    wait_finish("b2b_first");
    @(posedge clk);
    load_matrix(0, 2, 1'b0);
    start_in = 1'b0;
    wait_finish("b2b_second");
    repeat (3) @(negedge clk);
    check("b2b_count", got_q.size(), 2*N_ELEM);
    if (got_q.size() == 2*N_ELEM) begin
      check("b2b_r0", int'(got_q[32]), 20);
      check("b2b_r1", int'(got_q[40]), 52);
      check("b2b_r2", int'(got_q[48]), 84);
      check("b2b_r3", int'(got_q[63]), 116);
    end

    // Reset during COMPUTE, then a fresh matrix.
    got_q.delete();
    @(negedge clk); start_in = 1'b1;
    @(posedge clk);
    load_matrix(1, 0, 1'b0);
    start_in = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort_dout", int'(dout), 0);
    check("abort_dout_valid", int'(dout_valid), 0);
    check("abort_finish", int'(finish), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_output", got_q.size(), 0);
    start_in = 1'b1;
    @(posedge clk);
    load_matrix(0, 3, 1'b0);
    start_in = 1'b0;
    wait_finish("after_abort");
    repeat (2) @(negedge clk);
    check("after_abort_count", got_q.size(), N_ELEM);
    if (got_q.size() == N_ELEM) begin
      check("after_abort_p00", int'(got_q[0]), 30);
      check("after_abort_p37", int'(got_q[31]), 174);
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
